// File: rtl/multiword_add_seq.sv
// Multi-word add/subtract sequencer: streams WORDS W-bit slices, LSW first, through one
// external combinational adder and assembles the N-bit result, carry-out and overflow.
module multiword_add_seq #(
    parameter int W     = 16,
    parameter int WORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_valid,
    output logic                 start_ready,
    input  logic [W*WORDS-1:0]   op_a,
    input  logic [W*WORDS-1:0]   op_b,
    input  logic                 cin,
    input  logic                 sub,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [W*WORDS-1:0]   result,
    output logic                 cout,
    output logic                 ovf,
    output logic [W-1:0]         add_a,
    output logic [W-1:0]         add_b,
    output logic                 add_c0,
    input  logic [W-1:0]         add_f,
    input  logic                 add_c
);

    localparam int N  = W * WORDS;
    localparam int CW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    a_q, a_d;
    logic [N-1:0]    b_q, b_d;
    logic [N-1:0]    result_q, result_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            carry_q, carry_d;
    logic            cout_q, cout_d;
    logic            ovf_q, ovf_d;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // start_ready is high only in IDLE, res_valid only in DONE, so they never overlap.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (start_valid) begin
                    a_d     = op_a;
                    b_d     = op_b ^ {N{sub}};
                    carry_d = sub | cin;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                result_d[int'(cnt_q)*W +: W] = add_f;
                carry_d = add_c;
                a_d     = a_q >> W;
                b_d     = b_q >> W;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    // Overflow uses the sign bits of the MSW slice actually fed to the adder.
                    cout_d  = add_c;
                    ovf_d   = (add_a[W-1] == add_b[W-1]) & (add_f[W-1] != add_a[W-1]);
                    cnt_d   = '0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (res_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    assign start_ready = (state_q == S_IDLE);
    assign res_valid   = (state_q == S_DONE);
    assign result      = result_q;
    assign cout        = cout_q;
    assign ovf         = ovf_q;
    assign add_a       = (state_q == S_RUN) ? a_q[W-1:0] : '0;
    assign add_b       = (state_q == S_RUN) ? b_q[W-1:0] : '0;
    assign add_c0      = (state_q == S_RUN) ? carry_q : 1'b0;

endmodule

// File: tb/tb_multiword_add_seq.sv
// Bench for multiword_add_seq (W=16, WORDS=4) with a behavioural stand-in for the
// external 16-bit adder; directed vector table plus hand-written corner sequences.
module tb_multiword_add_seq;

    localparam int W     = 16;
    localparam int WORDS = 4;
    localparam int N     = W * WORDS;

    logic          clk;
    logic          rst_n;
    logic          start_valid;
    logic          start_ready;
    logic [N-1:0]  op_a;
    logic [N-1:0]  op_b;
    logic          cin;
    logic          sub;
    logic          res_valid;
    logic          res_ready;
    logic [N-1:0]  result;
    logic          cout;
    logic          ovf;
    logic [W-1:0]  add_a;
    logic [W-1:0]  add_b;
    logic          add_c0;
    logic [W-1:0]  add_f;
    logic          add_c;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    multiword_add_seq #(.W(W), .WORDS(WORDS)) dut (
        .clk(clk), .rst_n(rst_n),
        .start_valid(start_valid), .start_ready(start_ready),
        .op_a(op_a), .op_b(op_b), .cin(cin), .sub(sub),
        .res_valid(res_valid), .res_ready(res_ready),
        .result(result), .cout(cout), .ovf(ovf),
        .add_a(add_a), .add_b(add_b), .add_c0(add_c0),
        .add_f(add_f), .add_c(add_c)
    );

    // Stand-in for the external carry-lookahead adder.
    logic [W:0] stub_sum;
    assign stub_sum = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_c0};
    assign add_f = stub_sum[W-1:0];
    assign add_c = stub_sum[W];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic         c;
        logic         s;
        logic [N-1:0] exp_res;
        logic         exp_cout;
        logic         exp_ovf;
    } vec_t;

    vec_t vecs[8];
    logic [N-1:0] exp_q[$];

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
        end
    endtask

    // Present an operand at a negedge and complete the accept edge; returns at the next negedge.
    task automatic start_op(input logic [N-1:0] a, input logic [N-1:0] b,
                            input logic c, input logic s);
        @(negedge clk);
        check("start_ready_before_accept", {63'd0, start_ready}, 64'd1);
        op_a = a; op_b = b; cin = c; sub = s; start_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_valid = 1'b0;
        op_a = {$urandom, $urandom}; op_b = {$urandom, $urandom};
        cin = 1'(~c); sub = 1'(~s);
    endtask

    // Count edges after the accept edge until res_valid is seen (bounded).
    task automatic wait_result(output int lat);
        lat = 0;
        while (!res_valid && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        if (!res_valid) begin
            n_checks++;
            n_fail++;
            $display("FAIL res_valid_timeout: no result after %0d cycles", lat);
        end
    endtask

    task automatic handoff();
        res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        res_ready = 1'b0;
        check("res_valid_after_handoff", {63'd0, res_valid}, 64'd0);
        check("start_ready_after_handoff", {63'd0, start_ready}, 64'd1);
    endtask

    initial begin
        int lat;
        logic [N-1:0] hold_res;
        logic [N:0]   wide;
        logic [N-1:0] ra, rb;
        logic         rc;
        int           acc_cyc[8];

        vecs[0] = '{64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0};
        vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0};
        vecs[2] = '{64'h1111_1111_1111_1111, 64'h1111_1111_1111_1111, 1'b0, 1'b0, 64'h2222_2222_2222_2222, 1'b0, 1'b0};
        vecs[3] = '{64'h5, 64'h7, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
        vecs[4] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
        vecs[5] = '{64'h7, 64'h5, 1'b1, 1'b1, 64'h2, 1'b1, 1'b0};
        vecs[6] = '{64'h8000_0000_0000_0000, 64'h1, 1'b0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
        vecs[7] = '{64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b1, 1'b0, 64'h0001_0000_0001_0001, 1'b0, 1'b0};

        rst_n = 1'b0; start_valid = 1'b0; res_ready = 1'b0;
        op_a = '0; op_b = '0; cin = 1'b0; sub = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_start_ready", {63'd0, start_ready}, 64'd1);
        check("reset_res_valid", {63'd0, res_valid}, 64'd0);
        check("reset_result", result, 64'd0);
        check("reset_cout_ovf", {62'd0, cout, ovf}, 64'd0);
        check("reset_adder_if", {47'd0, add_a == 16'd0, add_b, add_c0}, {47'd0, 1'b1, 16'd0, 1'b0});
        rst_n = 1'b1;

        // Directed table
        for (int i = 0; i < 8; i++) begin
            start_op(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].s);
            wait_result(lat);
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'd4);
            check($sformatf("vec%0d_result", i), result, vecs[i].exp_res);
            check($sformatf("vec%0d_cout", i), {63'd0, cout}, {63'd0, vecs[i].exp_cout});
            check($sformatf("vec%0d_ovf", i), {63'd0, ovf}, {63'd0, vecs[i].exp_ovf});
            handoff();
            check($sformatf("vec%0d_result_kept", i), result, vecs[i].exp_res);
        end

        // Backpressure in DONE: outputs held, extra start ignored
        start_op(64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b0, 1'b0);
        wait_result(lat);
        hold_res = 64'h1234_5678_9ABC_DF00;
        for (int k = 0; k < 3; k++) begin
            start_valid = (k == 1);
            op_a = 64'hDEAD; op_b = 64'hBEEF;
            @(posedge clk);
            @(negedge clk);
            check("bp_res_valid", {63'd0, res_valid}, 64'd1);
            check("bp_start_ready", {63'd0, start_ready}, 64'd0);
            check("bp_result", result, hold_res);
            check("bp_cout_ovf", {62'd0, cout, ovf}, 64'd0);
        end
        start_valid = 1'b0;
        handoff();
        @(negedge clk);
        check("bp_no_queued_op", {63'd0, start_ready}, 64'd1);

        // Reset in the second RUN cycle discards the operation
        start_op(64'h1234_5678_9ABC_DEF0, 64'h1, 1'b0, 1'b0);
        check("run_word0_add_a", {48'd0, add_a}, 64'hDEF0);
        check("run_word0_add_b", {48'd0, add_b}, 64'h0001);
        @(posedge clk);
        @(negedge clk);
        check("run_word1_add_a", {48'd0, add_a}, 64'h9ABC);
        check("run_word1_add_c0", {63'd0, add_c0}, 64'd0);
        rst_n = 1'b0;
        #1;
        check("midrst_start_ready", {63'd0, start_ready}, 64'd1);
        check("midrst_res_valid", {63'd0, res_valid}, 64'd0);
        check("midrst_result", result, 64'd0);
        check("midrst_cout_ovf", {62'd0, cout, ovf}, 64'd0);
        check("midrst_adder_if", {47'd0, add_a, add_c0}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        start_op(64'd3, 64'd4, 1'b0, 1'b0);
        wait_result(lat);
        check("postrst_result", result, 64'd7);
        handoff();

        // Back-to-back random ops with res_ready held high
        res_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            rc = 1'($urandom_range(0, 1));
            wide = {1'b0, ra} + {1'b0, rb} + {{N{1'b0}}, rc};
            exp_q.push_back(wide[N-1:0]);
            lat = 0;
            while (!start_ready && lat < 20) begin
                @(negedge clk);
                lat++;
            end
            op_a = ra; op_b = rb; cin = rc; sub = 1'b0; start_valid = 1'b1;
            @(posedge clk);
            acc_cyc[i] = cyc;
            @(negedge clk);
            wait_result(lat);
            check($sformatf("b2b%0d_result", i), result, exp_q.pop_front());
            check($sformatf("b2b%0d_cout", i), {63'd0, cout}, {63'd0, wide[N]});
            if (i > 0)
                check($sformatf("b2b%0d_period", i), 64'(acc_cyc[i] - acc_cyc[i-1]), 64'd6);
            @(negedge clk);
        end
        start_valid = 1'b0;
        res_ready = 1'b0;
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
